// File: rtl/branch_resolve_unit_pkg.sv
// Shared opcode/funct3 constants and BHT initial-value helper for the EX-stage branch resolver.
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_ctrl;
  } ctrl_dec_t;

  // Weakly not-taken: one below the midpoint, which is 0 for a 1-bit counter.
  function automatic int unsigned bht_init(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch resolution bus: operands and prediction in, outcome, redirect and BHT lookup out.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) ();
  logic             valid_i;
  logic             stall_i;
  logic             flush_i;
  logic [6:0]       opcode_i;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  imm_i;
  logic             pred_taken_i;
  logic [XLEN-1:0]  pred_target_i;
  logic [XLEN-1:0]  if_pc_i;
  logic             if_pred_taken_o;
  logic             res_valid_o;
  logic             res_taken_o;
  logic [XLEN-1:0]  res_target_o;
  logic             mispredict_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic [CNT_W-1:0] taken_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output valid_i, stall_i, flush_i, opcode_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i,
           pred_taken_i, pred_target_i, if_pc_i,
    input  if_pred_taken_o, res_valid_o, res_taken_o, res_target_o, mispredict_o,
           redirect_pc_o, taken_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, opcode_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i,
           pred_taken_i, pred_target_i, if_pc_i,
    output if_pred_taken_o, res_valid_o, res_taken_o, res_target_o, mispredict_o,
           redirect_pc_o, taken_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational operand comparator: equality, signed and unsigned less-than from one subtractor.
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);
  logic [XLEN:0] diff;

  assign diff = {1'b0, rs1} - {1'b0, rs2};
  assign eq   = (diff == '0);
  assign ltu  = diff[XLEN];
  // With differing signs the negative operand is the smaller one; otherwise the sign of the difference decides.
  assign lt   = (rs1[XLEN-1] != rs2[XLEN-1]) ? rs1[XLEN-1] : diff[XLEN-1];
endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates B-type/JAL/JALR, registers the outcome and redirect,
// trains a saturating-counter BHT read combinationally by IF, and counts taken/mispredicted transfers.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_BITS  = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(bht_init(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic            eq, lt, ltu;
  ctrl_dec_t       dec;
  logic            br_ok;
  logic            cond;
  logic            taken_next;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] rs1_imm;
  logic [XLEN-1:0] target_next;
  logic [XLEN-1:0] redirect_next;
  logic            mispredict_next;
  logic            capture;

  logic             valid_reg;
  logic             taken_reg;
  logic [XLEN-1:0]  target_reg;
  logic             mispredict_reg;
  logic [XLEN-1:0]  redirect_reg;
  logic [CNT_W-1:0] taken_cnt_reg;
  logic [CNT_W-1:0] mispred_cnt_reg;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1 (bus.rs1_i),
    .rs2 (bus.rs2_i),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  always_comb begin
    dec           = '0;
    dec.is_branch = (bus.opcode_i == OPC_BRANCH);
    dec.is_jal    = (bus.opcode_i == OPC_JAL);
    dec.is_jalr   = (bus.opcode_i == OPC_JALR);
    // funct3 010/011 are not defined for branches and are treated as non-control.
    dec.is_ctrl   = (dec.is_branch && (bus.funct3_i[2:1] != 2'b01)) || dec.is_jal || dec.is_jalr;
  end

  assign br_ok = dec.is_branch && (bus.funct3_i[2:1] != 2'b01);

  always_comb begin
    cond = 1'b0;
    case (bus.funct3_i)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = !lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  assign pc_imm          = bus.pc_i + bus.imm_i;
  assign rs1_imm         = bus.rs1_i + bus.imm_i;
  assign taken_next      = dec.is_jal || dec.is_jalr || (br_ok && cond);
  assign target_next     = dec.is_jalr ? {rs1_imm[XLEN-1:1], 1'b0} : pc_imm;
  assign redirect_next   = taken_next ? target_next : (bus.pc_i + XLEN'(4));
  assign mispredict_next = (taken_next != bus.pred_taken_i) ||
                           (taken_next && (target_next != bus.pred_target_i));
  assign capture         = bus.valid_i && !bus.stall_i && !bus.flush_i;

  // Flush wins over stall; stall freezes everything; an empty slot drops only valid/mispredict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg       <= 1'b0;
      taken_reg       <= 1'b0;
      target_reg      <= '0;
      mispredict_reg  <= 1'b0;
      redirect_reg    <= '0;
      taken_cnt_reg   <= '0;
      mispred_cnt_reg <= '0;
    end else if (bus.flush_i) begin
      valid_reg      <= 1'b0;
      mispredict_reg <= 1'b0;
    end else if (bus.stall_i) begin
      valid_reg <= valid_reg;
    end else if (bus.valid_i) begin
      valid_reg      <= 1'b1;
      taken_reg      <= taken_next;
      target_reg     <= target_next;
      mispredict_reg <= mispredict_next;
      redirect_reg   <= redirect_next;
      if (dec.is_ctrl && taken_next) begin
        taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
      end
      if (dec.is_ctrl && mispredict_next) begin
        mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
      end
    end else begin
      valid_reg      <= 1'b0;
      mispredict_reg <= 1'b0;
    end
  end

  // BHT held in flops so the whole table clears on reset and IF can read it combinationally.
  logic [BHT_DEPTH-1:0][CTR_BITS-1:0] bht_q;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;
  logic                bht_we;

  assign wr_idx  = bus.pc_i[IDX_W+1:2];
  assign rd_idx  = bus.if_pc_i[IDX_W+1:2];
  assign ctr_cur = bht_q[wr_idx];
  assign bht_we  = capture && br_ok;

  always_comb begin
    ctr_next = ctr_cur;
    if (taken_next) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - CTR_BITS'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      logic [CTR_BITS-1:0] ctr_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctr_reg <= CTR_INIT;
        end else if (bht_we && (wr_idx == IDX_W'(gi))) begin
          ctr_reg <= ctr_next;
        end
      end
      assign bht_q[gi] = ctr_reg;
    end
  endgenerate

  logic unused_if_pc;
  assign unused_if_pc = &{1'b0, bus.if_pc_i[XLEN-1:IDX_W+2], bus.if_pc_i[1:0]};

  assign bus.if_pred_taken_o = bht_q[rd_idx][CTR_BITS-1];
  assign bus.res_valid_o     = valid_reg;
  assign bus.res_taken_o     = taken_reg;
  assign bus.res_target_o    = target_reg;
  assign bus.mispredict_o    = mispredict_reg;
  assign bus.redirect_pc_o   = redirect_reg;
  assign bus.taken_cnt_o     = taken_cnt_reg;
  assign bus.mispred_cnt_o   = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit with hand sequences for stall/flush, BHT and reset.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_resolve_unit #(
    .XLEN(32), .BHT_DEPTH(64), .CTR_BITS(2), .CNT_W(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        chk_tgt;
    logic        e_mis;
    logic [31:0] e_redir;
    logic        counts;
  } vec_t;

  localparam logic [6:0] OPC_OP = 7'b0110011;

  vec_t vecs[13];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_tc = 0;
  int exp_mc = 0;

  function automatic vec_t mk(logic [6:0] opc, logic [2:0] f3, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] pc, logic [31:0] imm, logic pt, logic [31:0] ptgt,
                              logic et, logic [31:0] etgt, logic ct, logic em, logic [31:0] er,
                              logic cnt);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm;
    v.pt = pt; v.ptgt = ptgt; v.e_taken = et; v.e_tgt = etgt; v.chk_tgt = ct;
    v.e_mis = em; v.e_redir = er; v.counts = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.valid_i = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    bus.opcode_i = 7'd0; bus.funct3_i = 3'd0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.pc_i = '0; bus.imm_i = '0; bus.pred_taken_i = 1'b0; bus.pred_target_i = '0;
  endtask

  task automatic apply(input vec_t v);
    bus.valid_i = 1'b1; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    bus.opcode_i = v.opc; bus.funct3_i = v.f3; bus.rs1_i = v.rs1; bus.rs2_i = v.rs2;
    bus.pc_i = v.pc; bus.imm_i = v.imm; bus.pred_taken_i = v.pt; bus.pred_target_i = v.ptgt;
  endtask

  // One BEQ at pc 0x40 (BHT index 16), predicted not-taken; checks the pred read after the edge.
  task automatic beq40(input logic tk, input logic [2:0] f3, input logic exp_pred, input string tag);
    vec_t v;
    logic ctrl;
    ctrl = (f3 == F3_BEQ);
    v = mk(OPC_BRANCH, f3, 32'd1, tk ? 32'd1 : 32'd2, 32'h40, 32'h80, 1'b0, 32'h0,
           tk && ctrl, 32'hC0, 1'b1, tk && ctrl, (tk && ctrl) ? 32'hC0 : 32'h44, ctrl);
    apply(v);
    if (v.counts && v.e_taken) exp_tc++;
    if (v.counts && v.e_mis) exp_mc++;
    @(negedge clk);
    $display("bht %s: taken=%0b pred=%0b", tag, bus.res_taken_o, bus.if_pred_taken_o);
    chk({tag, " taken"}, {31'd0, bus.res_taken_o}, {31'd0, v.e_taken});
    chk({tag, " if_pred"}, {31'd0, bus.if_pred_taken_o}, {31'd0, exp_pred});
  endtask

  initial begin
    vecs[0]  = mk(OPC_BRANCH, F3_BLT,  32'h8000_0000, 32'd1, 32'h200, 32'h20, 1'b0, 32'h0,
                  1'b1, 32'h220, 1'b1, 1'b1, 32'h220, 1'b1);
    vecs[1]  = mk(OPC_BRANCH, F3_BGEU, 32'd5, 32'hFFFF_FFFF, 32'h100, 32'h10, 1'b0, 32'h0,
                  1'b0, 32'h110, 1'b1, 1'b0, 32'h104, 1'b1);
    vecs[2]  = mk(OPC_BRANCH, F3_BLTU, 32'd5, 32'hFFFF_FFFF, 32'h100, 32'h10, 1'b0, 32'h0,
                  1'b1, 32'h110, 1'b1, 1'b1, 32'h110, 1'b1);
    vecs[3]  = mk(OPC_JALR, 3'd0, 32'h1001, 32'd0, 32'h80, 32'd2, 1'b1, 32'h1002,
                  1'b1, 32'h1002, 1'b1, 1'b0, 32'h1002, 1'b1);
    vecs[4]  = mk(OPC_JALR, 3'd0, 32'h1001, 32'd0, 32'h80, 32'd2, 1'b1, 32'h1004,
                  1'b1, 32'h1002, 1'b1, 1'b1, 32'h1002, 1'b1);
    vecs[5]  = mk(OPC_BRANCH, F3_BEQ, 32'd7, 32'd7, 32'h300, 32'hFFFF_FFF8, 1'b1, 32'h2F8,
                  1'b1, 32'h2F8, 1'b1, 1'b0, 32'h2F8, 1'b1);
    vecs[6]  = mk(OPC_BRANCH, F3_BNE, 32'd7, 32'd7, 32'h300, 32'hFFFF_FFF8, 1'b1, 32'h2F8,
                  1'b0, 32'h2F8, 1'b1, 1'b1, 32'h304, 1'b1);
    vecs[7]  = mk(OPC_BRANCH, F3_BGE, 32'hFFFF_FFFF, 32'd0, 32'h400, 32'h40, 1'b0, 32'h0,
                  1'b0, 32'h440, 1'b1, 1'b0, 32'h404, 1'b1);
    vecs[8]  = mk(OPC_JAL, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'd4,
                  1'b1, 32'd4, 1'b1, 1'b0, 32'd4, 1'b1);
    vecs[9]  = mk(OPC_BRANCH, 3'b010, 32'd3, 32'd3, 32'h500, 32'h10, 1'b1, 32'h510,
                  1'b0, 32'h0, 1'b0, 1'b1, 32'h504, 1'b0);
    vecs[10] = mk(OPC_OP, 3'd0, 32'd3, 32'd3, 32'h510, 32'h10, 1'b0, 32'h0,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h514, 1'b0);
    vecs[11] = mk(OPC_BRANCH, F3_BLT, 32'd1, 32'd2, 32'h520, 32'h100, 1'b1, 32'h620,
                  1'b1, 32'h620, 1'b1, 1'b0, 32'h620, 1'b1);
    vecs[12] = mk(OPC_BRANCH, F3_BLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h600, 32'h10, 1'b1, 32'h610,
                  1'b0, 32'h610, 1'b1, 1'b1, 32'h604, 1'b1);

    idle();
    bus.if_pc_i = 32'h40;
    @(negedge clk);
    chk("reset res_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("reset mispredict", {31'd0, bus.mispredict_o}, 32'd0);
    chk("reset redirect", bus.redirect_pc_o, 32'd0);
    chk("reset taken_cnt", bus.taken_cnt_o, 32'd0);
    chk("reset if_pred", {31'd0, bus.if_pred_taken_o}, 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      if (vecs[i].counts && vecs[i].e_taken) exp_tc++;
      if (vecs[i].counts && vecs[i].e_mis) exp_mc++;
      @(negedge clk);
      $display("vec %0d: taken=%0b target=0x%08h mispredict=%0b redirect=0x%08h", i,
               bus.res_taken_o, bus.res_target_o, bus.mispredict_o, bus.redirect_pc_o);
      chk($sformatf("vec%0d res_valid", i), {31'd0, bus.res_valid_o}, 32'd1);
      chk($sformatf("vec%0d taken", i), {31'd0, bus.res_taken_o}, {31'd0, vecs[i].e_taken});
      chk($sformatf("vec%0d mispredict", i), {31'd0, bus.mispredict_o}, {31'd0, vecs[i].e_mis});
      chk($sformatf("vec%0d redirect", i), bus.redirect_pc_o, vecs[i].e_redir);
      if (vecs[i].chk_tgt) chk($sformatf("vec%0d target", i), bus.res_target_o, vecs[i].e_tgt);
      chk($sformatf("vec%0d taken_cnt", i), bus.taken_cnt_o, 32'(exp_tc));
      chk($sformatf("vec%0d mispred_cnt", i), bus.mispred_cnt_o, 32'(exp_mc));
    end

    // Stall with a new taken branch at 0x40 pending: everything holds, BHT untouched.
    apply(mk(OPC_BRANCH, F3_BEQ, 32'd9, 32'd9, 32'h40, 32'h80, 1'b0, 32'h0,
             1'b1, 32'hC0, 1'b1, 1'b1, 32'hC0, 1'b1));
    bus.stall_i = 1'b1;
    @(negedge clk);
    $display("stall: valid=%0b mispredict=%0b redirect=0x%08h", bus.res_valid_o, bus.mispredict_o,
             bus.redirect_pc_o);
    chk("stall res_valid", {31'd0, bus.res_valid_o}, 32'd1);
    chk("stall mispredict", {31'd0, bus.mispredict_o}, 32'd1);
    chk("stall redirect", bus.redirect_pc_o, 32'h604);
    chk("stall taken_cnt", bus.taken_cnt_o, 32'(exp_tc));
    chk("stall if_pred", {31'd0, bus.if_pred_taken_o}, 32'd0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    $display("flush: valid=%0b mispredict=%0b", bus.res_valid_o, bus.mispredict_o);
    chk("flush res_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("flush mispredict", {31'd0, bus.mispredict_o}, 32'd0);
    chk("flush taken_cnt", bus.taken_cnt_o, 32'(exp_tc));
    chk("flush mispred_cnt", bus.mispred_cnt_o, 32'(exp_mc));
    chk("flush if_pred", {31'd0, bus.if_pred_taken_o}, 32'd0);
    idle();
    @(negedge clk);
    chk("idle res_valid", {31'd0, bus.res_valid_o}, 32'd0);

    // Same-cycle read before the update edge sees the old counter (1 -> MSB 0).
    apply(mk(OPC_BRANCH, F3_BEQ, 32'd1, 32'd1, 32'h40, 32'h80, 1'b0, 32'h0,
             1'b1, 32'hC0, 1'b1, 1'b1, 32'hC0, 1'b1));
    #1;
    chk("bht old read", {31'd0, bus.if_pred_taken_o}, 32'd0);
    @(negedge clk);
    idle();
    exp_tc++; exp_mc++;
    chk("bht t1 if_pred", {31'd0, bus.if_pred_taken_o}, 32'd1);
    beq40(1'b1, F3_BEQ, 1'b1, "t2");
    beq40(1'b1, F3_BEQ, 1'b1, "t3");
    beq40(1'b1, F3_BEQ, 1'b1, "t4");
    beq40(1'b0, F3_BEQ, 1'b1, "n1");
    beq40(1'b0, F3_BEQ, 1'b0, "n2");
    beq40(1'b0, F3_BEQ, 1'b0, "n3");
    beq40(1'b0, F3_BEQ, 1'b0, "n4");
    beq40(1'b1, F3_BEQ, 1'b0, "u1");
    beq40(1'b1, F3_BEQ, 1'b1, "u2");
    beq40(1'b1, F3_BEQ, 1'b1, "u3");
    chk("train taken_cnt", bus.taken_cnt_o, 32'(exp_tc));
    chk("train mispred_cnt", bus.mispred_cnt_o, 32'(exp_mc));

    // Asynchronous reset in the middle of a cycle clears outputs, counters and the BHT at once.
    apply(mk(OPC_BRANCH, F3_BEQ, 32'd1, 32'd1, 32'h40, 32'h80, 1'b0, 32'h0,
             1'b1, 32'hC0, 1'b1, 1'b1, 32'hC0, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset mid-stream: valid=%0b taken_cnt=%0d pred=%0b", bus.res_valid_o,
             bus.taken_cnt_o, bus.if_pred_taken_o);
    chk("mid-rst res_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("mid-rst res_taken", {31'd0, bus.res_taken_o}, 32'd0);
    chk("mid-rst redirect", bus.redirect_pc_o, 32'd0);
    chk("mid-rst taken_cnt", bus.taken_cnt_o, 32'd0);
    chk("mid-rst mispred_cnt", bus.mispred_cnt_o, 32'd0);
    chk("mid-rst if_pred", {31'd0, bus.if_pred_taken_o}, 32'd0);
    exp_tc = 0; exp_mc = 0;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);

    // Undefined funct3 never trains the BHT or counts; a following real taken BEQ lifts 1 -> 2.
    beq40(1'b1, 3'b010, 1'b0, "f010a");
    chk("f010a mispredict", {31'd0, bus.mispredict_o}, 32'd0);
    beq40(1'b0, 3'b010, 1'b0, "f010b");
    chk("f010 taken_cnt", bus.taken_cnt_o, 32'd0);
    chk("f010 mispred_cnt", bus.mispred_cnt_o, 32'd0);
    beq40(1'b1, F3_BEQ, 1'b1, "after010");
    chk("after010 taken_cnt", bus.taken_cnt_o, 32'(exp_tc));
    idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
